// File: rtl/dff_write_arbiter_pkg.sv
// Shared types and helpers for the shared-register write arbiter.
package dff_arb_pkg;

    // Widest requester vector the one-hot helper can produce.
    localparam int ARB_MAX_REQ = 32;

    // Arbiter FSM: free arbitration, or exclusive ownership by one requester.
    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // One-hot vector with bit idx set; all-zero when idx is outside [0, width).
    function automatic logic [ARB_MAX_REQ-1:0] onehot(input int idx, input int width);
        logic [ARB_MAX_REQ-1:0] v;
        v = '0;
        if ((idx >= 0) && (idx < width) && (idx < ARB_MAX_REQ)) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/dff_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of eff strictly after
// 'last', wrapping at NUM_REQ (which need not be a power of two).
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eff,
    input  logic [IDW-1:0]     last,
    output logic               found,
    output logic [IDW-1:0]     winner
);

    // Walk the NUM_REQ candidates in priority order; the first hit wins.
    // The wrap is a single subtract because 'last' is always < NUM_REQ.
    always_comb begin : pick
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && eff[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter owning a shared N-bit register, with an
// exclusive lock mode for bursts from a single requester.
//
// Handshake: a requester raises req[i] with wdata slice i and holds both
// until ack[i] pulses for one cycle; ack[i] coincides with q carrying that
// data. req[i] is ignored while ack[i] is high, so a held request is never
// written twice by the same grant. lock[i] is sampled on the winning edge.
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   lock,
    input  logic [NUM_REQ*N-1:0] wdata,
    output logic [NUM_REQ-1:0]   ack,
    output logic [N-1:0]         q,
    output logic                 q_valid,
    output logic [IDW-1:0]       owner,
    output logic                 busy,
    output arb_state_t           dbg_state
);

    // Registered state
    arb_state_t           state_q, state_d;
    logic [N-1:0]         q_q, q_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [IDW-1:0]       owner_q, owner_d;
    logic [IDW-1:0]       last_q, last_d;
    logic                 q_valid_q, q_valid_d;

    // Arbitration signals
    logic [NUM_REQ-1:0]   eff;
    logic                 pick_found;
    logic [IDW-1:0]       pick_idx;
    logic                 write_en;
    logic [IDW-1:0]       write_idx;
    logic [N-1:0]         wr_data;

    // A requester acked this cycle is masked so it cannot win twice in a row.
    always_comb begin
        eff = req & ~ack_q;
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .eff    (eff),
        .last   (last_q),
        .found  (pick_found),
        .winner (pick_idx)
    );

    // FSM: decide whether a write happens this edge, by whom, and the next state.
    always_comb begin
        state_d   = state_q;
        write_en  = 1'b0;
        write_idx = pick_idx;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    write_en  = 1'b1;
                    write_idx = pick_idx;
                    if (lock[pick_idx]) begin
                        state_d = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                // Only the lock holder is served; everyone else waits.
                if (eff[owner_q]) begin
                    write_en  = 1'b1;
                    write_idx = owner_q;
                    if (!lock[owner_q]) begin
                        state_d = ARB_IDLE;
                    end
                end else if (!req[owner_q] && !lock[owner_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Data mux: select the winning requester's slice.
    always_comb begin
        wr_data = wdata[int'(write_idx)*N +: N];
    end

    // Register, ack, owner and pointer updates; everything holds without a write.
    always_comb begin
        q_d       = q_q;
        ack_d     = '0;
        owner_d   = owner_q;
        last_d    = last_q;
        q_valid_d = q_valid_q;
        if (write_en) begin
            q_d       = wr_data;
            ack_d     = NUM_REQ'(onehot(int'(write_idx), NUM_REQ));
            owner_d   = write_idx;
            last_d    = write_idx;
            q_valid_d = 1'b1;
        end
    end

    // State flops; reset leaves requester 0 with first priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            q_q       <= '0;
            ack_q     <= '0;
            owner_q   <= '0;
            last_q    <= IDW'(NUM_REQ - 1);
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            ack_q     <= ack_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            q_valid_q <= q_valid_d;
        end
    end

    // All outputs come straight from flops.
    always_comb begin
        ack       = ack_q;
        q         = q_q;
        q_valid   = q_valid_q;
        owner     = owner_q;
        busy      = (state_q == ARB_LOCKED);
        dbg_state = state_q;
    end

endmodule
